mem_arbiter: RTL
================

# mem_arbiter

Request scheduler in front of the byte-serial RAM engine: shares the single engine between instruction-line refill, LSB loads and LSB stores. Grants one transaction at a time, forwards its command, and routes completion back to the owner. Also enforces speculation (roll_back) and UART back-pressure (io_buffer_full) rules, so the engine itself stays policy-free.

## Interface
Parameters:
- ADDR_W, 32, address width of all request ports
- DATA_W, 32, load/store data width
- STARVE_LIMIT, 4, LSB grants tolerated while fetch waits before fetch is forced first (1..7)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_in  in  1  reset, asynchronous, active-low
- rdy_in  in  1  global ready; low freezes the block
- roll_back  in  1  mispredict flush
- io_buffer_full  in  1  UART buffer full
- if_req  in  1  line-refill request
- if_addr  in  ADDR_W  refill line address
- if_gnt  out  1  one-cycle grant pulse to fetch
- if_done  out  1  one-cycle refill-complete pulse
- ld_req  in  1  load request
- ld_addr  in  ADDR_W  load address
- ld_width  in  2  bytes-1 (0=byte, 1=half, 3=word)
- ld_gnt  out  1  one-cycle grant pulse to load
- ld_done  out  1  one-cycle load-complete pulse
- ld_data  out  DATA_W  load result, valid with ld_done, held until next load completes
- st_req, st_addr, st_width, st_data  in  1/ADDR_W/2/DATA_W  store request
- st_gnt, st_done  out  1  one-cycle grant / complete pulses to store
- eng_start  out  1  one-cycle command pulse to engine
- eng_kind  out  2  0=fetch, 1=load, 2=store
- eng_addr, eng_width, eng_wdata  out  ADDR_W/2/DATA_W  command fields, held stable while BUSY
- eng_abort  out  1  one-cycle cancel pulse to engine
- eng_done  in  1  engine transaction complete
- eng_rdata  in  DATA_W  engine read data, valid with eng_done

## Operation
- States: IDLE, BUSY. Owner register {FETCH, LOAD, STORE}; starve_cnt 3 bits.
- IDLE, pick winner among asserted reqs:
  - if_req && starve_cnt == STARVE_LIMIT → fetch.
  - else store > load > fetch.
  - Store with st_addr[17:16]==2'b11 is ineligible while io_buffer_full=1; load/fetch may win instead.
  - On win: latch command, pulse eng_start + matching gnt, owner←winner, → BUSY.
- roll_back=1 in IDLE: load and fetch ineligible that cycle; store still eligible (committed).
- starve_cnt: +1 (saturating at STARVE_LIMIT) on every load/store grant while if_req=1; cleared on fetch grant.
- BUSY:
  - eng_done=1 → pulse owner's done. If owner LOAD, ld_data←eng_rdata. → IDLE.
  - roll_back=1 with owner LOAD or FETCH → pulse eng_abort, no done pulse, → IDLE. eng_done in same cycle is ignored.
  - roll_back with owner STORE: ignored; store completes normally.
- Requesters hold req/addr/data stable until gnt and drop req the cycle after gnt. Arbiter samples reqs only in IDLE.
- rdy_in=0 at an edge: no state/counter/latched-field change; all pulse outputs (gnt, done, eng_start, eng_abort) driven 0.

## Timing
- Reset: state IDLE, owner FETCH, starve_cnt 0, every output 0 (including eng_* fields and ld_data).
- Grant latency: req seen in IDLE at edge N → eng_start/gnt high after edge N, for one cycle.
- Completion: eng_done seen at edge M → done pulse after M, state IDLE. Earliest next eng_start after edge M+1; one idle cycle is mandatory between transactions.
- Abort: eng_abort high exactly one cycle, after the edge sampling roll_back. Arbiter is IDLE the same cycle.
- Pulses never exceed one cycle; at most one gnt and one done asserted per cycle.
- Reset asserted mid-transaction: immediate return to reset values; no done pulse emitted.

## Test plan
- Single word load 0x1004, engine returns 0xDEADBEEF after 5 cycles → ld_gnt +1 cycle, eng_kind=1, eng_width=3; ld_done one cycle after eng_done, ld_data=0xDEADBEEF.
- if_req, ld_req, st_req asserted together → store, then load, then fetch granted in that order, each eng_start separated by ≥1 idle cycle.
- if_req held while 4 load+store grants occur (STARVE_LIMIT=4) → next grant is fetch despite pending ld_req; starve_cnt returns 0.
- Store to 0x30000 with io_buffer_full=1 plus pending ld_req → load granted first; store granted only after io_buffer_full drops.
- roll_back during BUSY with load owner → eng_abort one cycle, no ld_done, IDLE next. Repeat with store owner → st_done still pulses.
- rdy_in low for 3 cycles across grant edge → no pulses while low; single eng_start after rdy_in returns. rst_in low mid-BUSY → all outputs 0 immediately.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Request/grant/completion bundle between the fetch/load/store requesters,
// the mem_arbiter and the byte-serial RAM engine.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_done;

    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic [1:0]        ld_width;
    logic              ld_gnt;
    logic              ld_done;
    logic [DATA_W-1:0] ld_data;

    logic              st_req;
    logic [ADDR_W-1:0] st_addr;
    logic [1:0]        st_width;
    logic [DATA_W-1:0] st_data;
    logic              st_gnt;
    logic              st_done;

    logic              eng_start;
    logic [1:0]        eng_kind;
    logic [ADDR_W-1:0] eng_addr;
    logic [1:0]        eng_width;
    logic [DATA_W-1:0] eng_wdata;
    logic              eng_abort;
    logic              eng_done;
    logic [DATA_W-1:0] eng_rdata;

    // Requesters and engine together form the master side.
    modport master (
        output if_req, if_addr, ld_req, ld_addr, ld_width,
        output st_req, st_addr, st_width, st_data, eng_done, eng_rdata,
        input  if_gnt, if_done, ld_gnt, ld_done, ld_data, st_gnt, st_done,
        input  eng_start, eng_kind, eng_addr, eng_width, eng_wdata, eng_abort
    );

    modport slave (
        input  if_req, if_addr, ld_req, ld_addr, ld_width,
        input  st_req, st_addr, st_width, st_data, eng_done, eng_rdata,
        output if_gnt, if_done, ld_gnt, ld_done, ld_data, st_gnt, st_done,
        output eng_start, eng_kind, eng_addr, eng_width, eng_wdata, eng_abort
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one RAM engine between fetch refill, loads and stores; applies the
// speculation (roll_back) and UART back-pressure rules before granting.
module mem_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst_in,
    input  logic         rdy_in,
    input  logic         roll_back,
    input  logic         io_buffer_full,
    mem_arbiter_if.slave bus
);
    typedef enum logic {StIdle, StBusy} state_e;
    typedef enum logic [1:0] {OwnFetch = 2'd0, OwnLoad = 2'd1, OwnStore = 2'd2} owner_e;

    localparam logic [2:0] StarveMax = 3'(STARVE_LIMIT);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [2:0]        starve_q, starve_d;
    logic [1:0]        kind_q, kind_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        width_q, width_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] ld_data_q, ld_data_d;
    // Pulse vectors are indexed {store, load, fetch}.
    logic [2:0]        gnt_q, gnt_d, done_q, done_d;
    logic              start_q, start_d, abort_q, abort_d;

    logic   fetch_ok, load_ok, store_ok, win_valid;
    owner_e win;

    always_comb begin
        fetch_ok  = bus.if_req && !roll_back;
        load_ok   = bus.ld_req && !roll_back;
        // Stores to the UART window wait while its buffer is full.
        store_ok  = bus.st_req && !(io_buffer_full && bus.st_addr[17:16] == 2'b11);
        win_valid = fetch_ok || load_ok || store_ok;
        win       = OwnFetch;
        if (fetch_ok && starve_q == StarveMax) win = OwnFetch;
        else if (store_ok)                     win = OwnStore;
        else if (load_ok)                      win = OwnLoad;
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        starve_d  = starve_q;
        kind_d    = kind_q;
        addr_d    = addr_q;
        width_d   = width_q;
        wdata_d   = wdata_q;
        ld_data_d = ld_data_q;
        gnt_d     = '0;
        done_d    = '0;
        start_d   = 1'b0;
        abort_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (win_valid) begin
                    state_d = StBusy;
                    owner_d = win;
                    kind_d  = win;
                    start_d = 1'b1;
                    unique case (win)
                        OwnLoad: begin
                            gnt_d[1] = 1'b1;
                            addr_d   = bus.ld_addr;
                            width_d  = bus.ld_width;
                            wdata_d  = '0;
                        end
                        OwnStore: begin
                            gnt_d[2] = 1'b1;
                            addr_d   = bus.st_addr;
                            width_d  = bus.st_width;
                            wdata_d  = bus.st_data;
                        end
                        default: begin
                            gnt_d[0] = 1'b1;
                            addr_d   = bus.if_addr;
                            width_d  = 2'd3;
                            wdata_d  = '0;
                        end
                    endcase
                    if (win == OwnFetch) begin
                        starve_d = '0;
                    end else if (bus.if_req && starve_q < StarveMax) begin
                        starve_d = starve_q + 3'd1;
                    end
                end
            end
            StBusy: begin
                // Committed stores are immune to a flush; speculative work is cancelled.
                if (roll_back && owner_q != OwnStore) begin
                    abort_d = 1'b1;
                    state_d = StIdle;
                end else if (bus.eng_done) begin
                    state_d = StIdle;
                    unique case (owner_q)
                        OwnLoad: begin
                            done_d[1] = 1'b1;
                            ld_data_d = bus.eng_rdata;
                        end
                        OwnStore: done_d[2] = 1'b1;
                        default:  done_d[0] = 1'b1;
                    endcase
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= StIdle;
            owner_q   <= OwnFetch;
            starve_q  <= '0;
            kind_q    <= '0;
            addr_q    <= '0;
            width_q   <= '0;
            wdata_q   <= '0;
            ld_data_q <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            start_q   <= 1'b0;
            abort_q   <= 1'b0;
        end else if (rdy_in) begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            starve_q  <= starve_d;
            kind_q    <= kind_d;
            addr_q    <= addr_d;
            width_q   <= width_d;
            wdata_q   <= wdata_d;
            ld_data_q <= ld_data_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            start_q   <= start_d;
            abort_q   <= abort_d;
        end else begin
            gnt_q   <= '0;
            done_q  <= '0;
            start_q <= 1'b0;
            abort_q <= 1'b0;
        end
    end

    assign bus.if_gnt    = gnt_q[0];
    assign bus.ld_gnt    = gnt_q[1];
    assign bus.st_gnt    = gnt_q[2];
    assign bus.if_done   = done_q[0];
    assign bus.ld_done   = done_q[1];
    assign bus.st_done   = done_q[2];
    assign bus.ld_data   = ld_data_q;
    assign bus.eng_start = start_q;
    assign bus.eng_kind  = kind_q;
    assign bus.eng_addr  = addr_q;
    assign bus.eng_width = width_q;
    assign bus.eng_wdata = wdata_q;
    assign bus.eng_abort = abort_q;
endmodule
